// File: rtl/pkt_rx_parser_pkg.sv
// Shared types and sizing for the NoC receive-side flit parser.
package pkt_rx_parser_pkg;

    localparam int unsigned FlitWidth     = 34;
    localparam int unsigned FlitDataWidth = FlitWidth - 2;
    localparam int unsigned NumVirtChn    = 3;
    localparam int unsigned VcWidth       = $clog2(NumVirtChn);
    localparam int unsigned PktWidth      = 8;
    localparam int unsigned MinDataWidth  = 32;

    typedef enum logic [1:0] {
        FLIT_HEAD = 2'b00,
        FLIT_BODY = 2'b01,
        FLIT_TAIL = 2'b10,
        FLIT_RSVD = 2'b11
    } flit_type_e;

    typedef enum logic {
        VC_IDLE   = 1'b0,
        VC_IN_PKT = 1'b1
    } vc_state_e;

    typedef struct packed {
        logic [FlitDataWidth-1:0] data;
        logic [VcWidth-1:0]       vc;
        logic                     first;
        logic                     last;
        logic [PktWidth-1:0]      sz;
    } s_pkt_rx_t;

    // Packet-size field carried in the head flit payload.
    function automatic logic [PktWidth-1:0] head_size(input logic [FlitDataWidth-1:0] payload);
        return payload[MinDataWidth-1 -: PktWidth];
    endfunction

endpackage

// File: rtl/pkt_rx_vc_fsm.sv
// Per-VC packet tracker: IDLE/IN_PKT state, latched size and, when
// PKT_RX_SZ_CHECK_EN is defined, a remaining-flit counter for size checks.
module pkt_rx_vc_fsm
    import pkt_rx_parser_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                acc_i,
    input  flit_type_e          type_i,
    input  logic [PktWidth-1:0] sz_i,
    output logic                pass_c_o,
    output logic                first_c_o,
    output logic                last_c_o,
    output logic                err_c_o,
    output logic [PktWidth-1:0] sz_c_o
);

    vc_state_e           state_q;
    logic [PktWidth-1:0] sz_q;
`ifdef PKT_RX_SZ_CHECK_EN
    logic [PktWidth-1:0] rem_q;
`endif

    // Classify the flit presented on this VC against the current packet state.
    always_comb begin
        pass_c_o  = 1'b0;
        first_c_o = 1'b0;
        last_c_o  = 1'b0;
        err_c_o   = 1'b0;
        sz_c_o    = sz_q;
        case (type_i)
            FLIT_HEAD: begin
                pass_c_o  = 1'b1;
                first_c_o = 1'b1;
                sz_c_o    = sz_i;
                last_c_o  = (sz_i == '0);
                err_c_o   = (state_q == VC_IN_PKT);
            end
            FLIT_BODY: begin
                if (state_q == VC_IDLE) begin
                    err_c_o = 1'b1;
                end else begin
                    pass_c_o = 1'b1;
`ifdef PKT_RX_SZ_CHECK_EN
                    if (rem_q == PktWidth'(1)) begin
                        last_c_o = 1'b1;
                        err_c_o  = 1'b1;
                    end
`endif
                end
            end
            FLIT_TAIL: begin
                if (state_q == VC_IDLE) begin
                    err_c_o = 1'b1;
                end else begin
                    pass_c_o = 1'b1;
                    last_c_o = 1'b1;
`ifdef PKT_RX_SZ_CHECK_EN
                    err_c_o  = (rem_q != PktWidth'(1));
`endif
                end
            end
            default: err_c_o = 1'b1;
        endcase
    end

    // Packet state update on accepted flits; reserved types leave state alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= VC_IDLE;
            sz_q    <= '0;
`ifdef PKT_RX_SZ_CHECK_EN
            rem_q   <= '0;
`endif
        end else if (acc_i) begin
            case (type_i)
                FLIT_HEAD: begin
                    sz_q    <= sz_i;
                    state_q <= (sz_i == '0) ? VC_IDLE : VC_IN_PKT;
`ifdef PKT_RX_SZ_CHECK_EN
                    rem_q   <= sz_i;
`endif
                end
                FLIT_BODY: begin
                    if (state_q == VC_IN_PKT) begin
                        if (last_c_o) state_q <= VC_IDLE;
`ifdef PKT_RX_SZ_CHECK_EN
                        rem_q <= (rem_q == '0) ? '0 : rem_q - PktWidth'(1);
`endif
                    end
                end
                FLIT_TAIL: begin
                    if (state_q == VC_IN_PKT) begin
                        state_q <= VC_IDLE;
`ifdef PKT_RX_SZ_CHECK_EN
                        rem_q   <= '0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pkt_rx_parser.sv
// NoC local-port receive parser: type decode, per-VC tracking, error flagging
// and a one-entry registered output stage. Optional size checking is enabled
// by defining PKT_RX_SZ_CHECK_EN.
module pkt_rx_parser
    import pkt_rx_parser_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flit_valid_i,
    output logic                     flit_ready_o,
    input  logic [FlitWidth-1:0]     flit_data_i,
    input  logic [VcWidth-1:0]       flit_vc_i,
    output logic                     pkt_valid_o,
    input  logic                     pkt_ready_i,
    output logic [FlitDataWidth-1:0] pkt_data_o,
    output logic [VcWidth-1:0]       pkt_vc_o,
    output logic                     pkt_first_o,
    output logic                     pkt_last_o,
    output logic [PktWidth-1:0]      pkt_sz_o,
    output logic                     err_o,
    output logic [VcWidth-1:0]       err_vc_o
);

    flit_type_e               ftype_c;
    logic [FlitDataWidth-1:0] payload_c;
    logic                     flit_acc_c;

    logic [NumVirtChn-1:0]    acc_v_c;
    logic [NumVirtChn-1:0]    pass_v_c;
    logic [NumVirtChn-1:0]    first_v_c;
    logic [NumVirtChn-1:0]    last_v_c;
    logic [NumVirtChn-1:0]    err_v_c;
    logic [PktWidth-1:0]      sz_v_c [NumVirtChn];

    logic                     sel_pass_c;
    logic                     sel_first_c;
    logic                     sel_last_c;
    logic                     sel_err_c;
    logic [PktWidth-1:0]      sel_sz_c;

    s_pkt_rx_t                out_d;
    s_pkt_rx_t                out_q;
    logic                     pkt_valid_q;
    logic                     err_q;
    logic [VcWidth-1:0]       err_vc_q;

    assign ftype_c      = flit_type_e'(flit_data_i[FlitWidth-1 -: 2]);
    assign payload_c    = flit_data_i[FlitDataWidth-1:0];
    assign flit_ready_o = !pkt_valid_q || pkt_ready_i;
    assign flit_acc_c   = flit_valid_i && flit_ready_o;

    for (genvar g = 0; g < NumVirtChn; g++) begin : g_vc
        assign acc_v_c[g] = flit_acc_c && (flit_vc_i == VcWidth'(g));

        pkt_rx_vc_fsm u_vc_fsm (
            .clk       (clk),
            .rst       (rst),
            .acc_i     (acc_v_c[g]),
            .type_i    (ftype_c),
            .sz_i      (head_size(payload_c)),
            .pass_c_o  (pass_v_c[g]),
            .first_c_o (first_v_c[g]),
            .last_c_o  (last_v_c[g]),
            .err_c_o   (err_v_c[g]),
            .sz_c_o    (sz_v_c[g])
        );
    end

    // Select the addressed VC's verdict; an unimplemented VC index is an error.
    always_comb begin
        sel_pass_c  = 1'b0;
        sel_first_c = 1'b0;
        sel_last_c  = 1'b0;
        sel_err_c   = 1'b1;
        sel_sz_c    = '0;
        for (int unsigned v = 0; v < NumVirtChn; v++) begin
            if (flit_vc_i == VcWidth'(v)) begin
                sel_pass_c  = pass_v_c[v];
                sel_first_c = first_v_c[v];
                sel_last_c  = last_v_c[v];
                sel_err_c   = err_v_c[v];
                sel_sz_c    = sz_v_c[v];
            end
        end
    end

    // Assemble the outgoing payload beat.
    always_comb begin
        out_d       = '0;
        out_d.data  = payload_c;
        out_d.vc    = flit_vc_i;
        out_d.first = sel_first_c;
        out_d.last  = sel_last_c;
        out_d.sz    = sel_sz_c;
    end

    // One-entry output register with hold on backpressure, plus error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_valid_q <= 1'b0;
            out_q       <= '0;
            err_q       <= 1'b0;
            err_vc_q    <= '0;
        end else begin
            if (flit_acc_c) begin
                pkt_valid_q <= sel_pass_c;
                if (sel_pass_c) out_q <= out_d;
            end else if (pkt_ready_i) begin
                pkt_valid_q <= 1'b0;
            end
            err_q <= flit_acc_c && sel_err_c;
            if (flit_acc_c && sel_err_c) err_vc_q <= flit_vc_i;
        end
    end

    assign pkt_valid_o = pkt_valid_q;
    assign pkt_data_o  = out_q.data;
    assign pkt_vc_o    = out_q.vc;
    assign pkt_first_o = out_q.first;
    assign pkt_last_o  = out_q.last;
    assign pkt_sz_o    = out_q.sz;
    assign err_o       = err_q;
    assign err_vc_o    = err_vc_q;

endmodule

// File: tb/tb_pkt_rx_parser.sv
// Self-checking bench for pkt_rx_parser: directed scenarios plus a randomized
// run scored against a packet-level reference model.
module tb_pkt_rx_parser;

`ifdef PKT_RX_SZ_CHECK_EN
    localparam bit SZ_CHK = 1'b1;
`else
    localparam bit SZ_CHK = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  vc;
        logic        first;
        logic        last;
        logic [7:0]  sz;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flit_valid_i;
    logic        flit_ready_o;
    logic [33:0] flit_data_i;
    logic [1:0]  flit_vc_i;
    logic        pkt_valid_o;
    logic        pkt_ready_i;
    logic [31:0] pkt_data_o;
    logic [1:0]  pkt_vc_o;
    logic        pkt_first_o;
    logic        pkt_last_o;
    logic [7:0]  pkt_sz_o;
    logic        err_o;
    logic [1:0]  err_vc_o;

    int tests = 0;
    int fails = 0;

    beat_t      got_q[$];
    beat_t      exp_q[$];
    logic [1:0] err_got_q[$];
    logic [1:0] err_exp_q[$];
    int         gb;
    int         eb;
    bit         rand_ready_en = 1'b0;

    // Reference model: per-VC open flag, flits still owed, latched size.
    bit open_m[3];
    int left_m[3];
    int psz_m[3];

    pkt_rx_parser dut (
        .clk          (clk),
        .rst          (rst),
        .flit_valid_i (flit_valid_i),
        .flit_ready_o (flit_ready_o),
        .flit_data_i  (flit_data_i),
        .flit_vc_i    (flit_vc_i),
        .pkt_valid_o  (pkt_valid_o),
        .pkt_ready_i  (pkt_ready_i),
        .pkt_data_o   (pkt_data_o),
        .pkt_vc_o     (pkt_vc_o),
        .pkt_first_o  (pkt_first_o),
        .pkt_last_o   (pkt_last_o),
        .pkt_sz_o     (pkt_sz_o),
        .err_o        (err_o),
        .err_vc_o     (err_vc_o)
    );

    always #5 clk = ~clk;

    // Record delivered beats and error pulses away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (pkt_valid_o && pkt_ready_i)
                got_q.push_back('{pkt_data_o, pkt_vc_o, pkt_first_o, pkt_last_o, pkt_sz_o});
            if (err_o)
                err_got_q.push_back(err_vc_o);
        end
    end

    task automatic model_flit(input logic [1:0] t, input logic [31:0] p, input logic [1:0] vc);
        int sz;
        bit fin;
        sz = int'(p[31:24]);
        case (t)
            2'b00: begin
                if (open_m[vc]) err_exp_q.push_back(vc);
                exp_q.push_back('{p, vc, 1'b1, (sz == 0), 8'(sz)});
                open_m[vc] = (sz != 0);
                left_m[vc] = sz;
                psz_m[vc]  = sz;
            end
            2'b01: begin
                if (!open_m[vc]) begin
                    err_exp_q.push_back(vc);
                end else begin
                    fin = SZ_CHK && (left_m[vc] == 1);
                    if (fin) err_exp_q.push_back(vc);
                    exp_q.push_back('{p, vc, 1'b0, fin, 8'(psz_m[vc])});
                    if (left_m[vc] > 0) left_m[vc] = left_m[vc] - 1;
                    if (fin) open_m[vc] = 1'b0;
                end
            end
            2'b10: begin
                if (!open_m[vc]) begin
                    err_exp_q.push_back(vc);
                end else begin
                    if (SZ_CHK && (left_m[vc] != 1)) err_exp_q.push_back(vc);
                    exp_q.push_back('{p, vc, 1'b0, 1'b1, 8'(psz_m[vc])});
                    open_m[vc] = 1'b0;
                    left_m[vc] = 0;
                end
            end
            default: err_exp_q.push_back(vc);
        endcase
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        flit_valid_i = 1'b0;
        flit_data_i  = '0;
        flit_vc_i    = '0;
        pkt_ready_i  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int v = 0; v < 3; v++) begin
            open_m[v] = 1'b0;
            left_m[v] = 0;
            psz_m[v]  = 0;
        end
        exp_q.delete();
        err_exp_q.delete();
        gb = got_q.size();
        eb = err_got_q.size();
    endtask

    // Present one flit until accepted (bounded), then feed it to the model.
    task automatic send(input logic [1:0] t, input logic [31:0] p, input logic [1:0] vc);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        flit_valid_i = 1'b1;
        flit_data_i  = {t, p};
        flit_vc_i    = vc;
        while (!done && n < 100) begin
            @(negedge clk);
            done = flit_ready_o;
            @(posedge clk);
            #1;
            if (rand_ready_en) pkt_ready_i = ($urandom_range(0, 3) != 0);
            n++;
        end
        flit_valid_i = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: flit not accepted after %0d cycles (need acceptance)", n);
        end else begin
            model_flit(t, p, vc);
        end
    endtask

    task automatic drain();
        pkt_ready_i = 1'b1;
        for (int c = 0; c < 100 && (got_q.size() - gb) < exp_q.size(); c++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        flit_valid_i = 1'b1;
        flit_data_i  = {2'b00, 32'h0300_0000};
        flit_vc_i    = 2'd0;
        pkt_ready_i  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({pkt_valid_o, pkt_data_o, pkt_vc_o, pkt_first_o, pkt_last_o, pkt_sz_o, err_o, err_vc_o} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b d=%h f=%b l=%b sz=%0d err=%b, need all zero",
                     pkt_valid_o, pkt_data_o, pkt_first_o, pkt_last_o, pkt_sz_o, err_o);
        end
        do_reset();
    endtask

    task automatic test_basic_pkt();
        logic [31:0] d[4];
        logic [1:0]  ty[4];
        d  = '{32'h0300_0000, 32'h11, 32'h22, 32'h33};
        ty = '{2'b00, 2'b01, 2'b01, 2'b10};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                flit_valid_i = 1'b1;
                flit_data_i  = {ty[k], d[k]};
                flit_vc_i    = 2'd0;
            end else begin
                flit_valid_i = 1'b0;
            end
            @(negedge clk);
            if (k > 0) begin
                tests++;
                if ({pkt_valid_o, pkt_data_o, pkt_first_o, pkt_last_o, pkt_sz_o, err_o}
                    !== {1'b1, d[k-1], (k == 1), (k == 4), 8'd3, 1'b0}) begin
                    fails++;
                    $display("FAIL basic_beat%0d: got v=%b d=%h f=%b l=%b sz=%0d err=%b, need v=1 d=%h f=%b l=%b sz=3 err=0",
                             k - 1, pkt_valid_o, pkt_data_o, pkt_first_o, pkt_last_o, pkt_sz_o, err_o,
                             d[k-1], (k == 1), (k == 4));
                end
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        tests++;
        if (pkt_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL basic_idle_after: got valid=%b need 0", pkt_valid_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero_size();
        do_reset();
        send(2'b00, 32'h0000_0ABC, 2'd1);
        @(negedge clk);
        tests++;
        if ({pkt_valid_o, pkt_vc_o, pkt_first_o, pkt_last_o, pkt_sz_o, err_o} !== {1'b1, 2'd1, 1'b1, 1'b1, 8'd0, 1'b0}) begin
            fails++;
            $display("FAIL zero_size_beat: got v=%b vc=%0d f=%b l=%b sz=%0d err=%b, need 1 1 1 1 0 0",
                     pkt_valid_o, pkt_vc_o, pkt_first_o, pkt_last_o, pkt_sz_o, err_o);
        end
        @(posedge clk);
        #1;
        send(2'b01, 32'h55, 2'd1);
        @(negedge clk);
        tests++;
        if ({err_o, err_vc_o, pkt_valid_o} !== {1'b1, 2'd1, 1'b0}) begin
            fails++;
            $display("FAIL zero_size_idle: got err=%b vc=%0d v=%b, need 1 1 0", err_o, err_vc_o, pkt_valid_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_interleave();
        int n;
        do_reset();
        send(2'b00, 32'h0200_0001, 2'd0);
        send(2'b00, 32'h0200_0002, 2'd2);
        send(2'b01, 32'hA0, 2'd0);
        send(2'b01, 32'hA2, 2'd2);
        send(2'b10, 32'hB0, 2'd0);
        send(2'b10, 32'hB2, 2'd2);
        drain();
        n = got_q.size() - gb;
        tests++;
        if (n !== exp_q.size()) begin
            fails++;
            $display("FAIL interleave_count: got %0d beats need %0d", n, exp_q.size());
        end
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[gb+i] !== exp_q[i]) begin
                fails++;
                $display("FAIL interleave_beat%0d: got %h need %h", i, got_q[gb+i], exp_q[i]);
            end
        end
        tests++;
        if ((err_got_q.size() - eb) !== 0) begin
            fails++;
            $display("FAIL interleave_err: got %0d error pulses need 0", err_got_q.size() - eb);
        end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        send(2'b00, 32'h0200_0077, 2'd0);
        pkt_ready_i  = 1'b0;
        flit_valid_i = 1'b1;
        flit_data_i  = {2'b01, 32'hBEEF};
        flit_vc_i    = 2'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if ({flit_ready_o, pkt_valid_o, pkt_data_o, pkt_first_o} !== {1'b0, 1'b1, 32'h0200_0077, 1'b1}) begin
                fails++;
                $display("FAIL stall_hold%0d: got rdy=%b v=%b d=%h f=%b, need 0 1 02000077 1",
                         c, flit_ready_o, pkt_valid_o, pkt_data_o, pkt_first_o);
            end
            @(posedge clk);
            #1;
        end
        pkt_ready_i = 1'b1;
        send(2'b01, 32'hBEEF, 2'd0);
        send(2'b10, 32'hCAFE, 2'd0);
        drain();
        n = got_q.size() - gb;
        tests++;
        if (n !== exp_q.size()) begin
            fails++;
            $display("FAIL stall_count: got %0d beats need %0d", n, exp_q.size());
        end
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[gb+i] !== exp_q[i]) begin
                fails++;
                $display("FAIL stall_beat%0d: got %h need %h", i, got_q[gb+i], exp_q[i]);
            end
        end
    endtask

    task automatic test_errors();
        int n;
        do_reset();
        send(2'b01, 32'h1234, 2'd1);
        @(negedge clk);
        tests++;
        if ({err_o, err_vc_o, pkt_valid_o} !== {1'b1, 2'd1, 1'b0}) begin
            fails++;
            $display("FAIL err_idle_body: got err=%b vc=%0d v=%b, need 1 1 0", err_o, err_vc_o, pkt_valid_o);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        tests++;
        if ({err_o, err_vc_o} !== {1'b0, 2'd1}) begin
            fails++;
            $display("FAIL err_pulse_width: got err=%b vc=%0d, need 0 1", err_o, err_vc_o);
        end
        @(posedge clk);
        #1;
        send(2'b00, 32'h0200_0010, 2'd0);
        send(2'b01, 32'h0000_0011, 2'd0);
        send(2'b00, 32'h0100_00AA, 2'd0);
        @(negedge clk);
        tests++;
        if ({err_o, err_vc_o, pkt_valid_o, pkt_first_o, pkt_last_o, pkt_sz_o}
            !== {1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 8'd1}) begin
            fails++;
            $display("FAIL err_head_in_pkt: got err=%b vc=%0d v=%b f=%b l=%b sz=%0d, need 1 0 1 1 0 1",
                     err_o, err_vc_o, pkt_valid_o, pkt_first_o, pkt_last_o, pkt_sz_o);
        end
        @(posedge clk);
        #1;
        send(2'b10, 32'h0000_00AB, 2'd0);
        send(2'b11, 32'h0000_00CD, 2'd2);
        drain();
        n = got_q.size() - gb;
        tests++;
        if (n !== exp_q.size()) begin
            fails++;
            $display("FAIL err_count: got %0d beats need %0d", n, exp_q.size());
        end
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[gb+i] !== exp_q[i]) begin
                fails++;
                $display("FAIL err_beat%0d: got %h need %h", i, got_q[gb+i], exp_q[i]);
            end
        end
        n = err_got_q.size() - eb;
        tests++;
        if (n !== err_exp_q.size()) begin
            fails++;
            $display("FAIL err_pulses: got %0d need %0d", n, err_exp_q.size());
        end
        for (int i = 0; i < n && i < err_exp_q.size(); i++) begin
            tests++;
            if (err_got_q[eb+i] !== err_exp_q[i]) begin
                fails++;
                $display("FAIL err_vc%0d: got %0d need %0d", i, err_got_q[eb+i], err_exp_q[i]);
            end
        end
    endtask

    task automatic test_size_check();
        do_reset();
        send(2'b00, 32'h0300_0000, 2'd2);
        send(2'b01, 32'h0000_0005, 2'd2);
        send(2'b10, 32'h0000_0006, 2'd2);
        @(negedge clk);
        tests++;
        if ({err_o, pkt_valid_o, pkt_last_o, pkt_data_o} !== {SZ_CHK, 1'b1, 1'b1, 32'h6}) begin
            fails++;
            $display("FAIL size_check_tail: got err=%b v=%b l=%b d=%h, need err=%b v=1 l=1 d=00000006",
                     err_o, pkt_valid_o, pkt_last_o, pkt_data_o, SZ_CHK);
        end
        @(posedge clk);
        #1;
        send(2'b00, 32'h0100_0000, 2'd2);
        send(2'b01, 32'h0000_0007, 2'd2);
        @(negedge clk);
        tests++;
        if ({err_o, pkt_last_o} !== {SZ_CHK, SZ_CHK}) begin
            fails++;
            $display("FAIL size_check_body: got err=%b l=%b, need err=%b l=%b", err_o, pkt_last_o, SZ_CHK, SZ_CHK);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_pkt();
        do_reset();
        send(2'b00, 32'h0400_0000, 2'd1);
        pkt_ready_i = 1'b0;
        rst         = 1'b1;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        pkt_ready_i = 1'b1;
        @(negedge clk);
        tests++;
        if (pkt_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_discard: got valid=%b need 0", pkt_valid_o);
        end
        @(posedge clk);
        #1;
        send(2'b10, 32'h0000_0099, 2'd1);
        @(negedge clk);
        tests++;
        if ({err_o, err_vc_o, pkt_valid_o} !== {1'b1, 2'd1, 1'b0}) begin
            fails++;
            $display("FAIL reset_mid_state: got err=%b vc=%0d v=%b, need 1 1 0", err_o, err_vc_o, pkt_valid_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int          n;
        logic [1:0]  vc;
        logic [1:0]  t;
        logic [31:0] p;
        do_reset();
        rand_ready_en = 1'b1;
        for (int k = 0; k < 400; k++) begin
            vc = 2'($urandom_range(0, 2));
            p  = {8'($urandom_range(0, 4)), 24'($urandom)};
            if ($urandom_range(0, 9) == 0)  t = 2'($urandom_range(0, 3));
            else if (!open_m[vc])           t = 2'b00;
            else if (left_m[vc] > 1)        t = 2'b01;
            else                            t = 2'b10;
            send(t, p, vc);
        end
        rand_ready_en = 1'b0;
        drain();
        n = got_q.size() - gb;
        tests++;
        if (n !== exp_q.size()) begin
            fails++;
            $display("FAIL random_count: got %0d beats need %0d", n, exp_q.size());
        end
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[gb+i] !== exp_q[i]) begin
                fails++;
                $display("FAIL random_beat%0d: got %h need %h", i, got_q[gb+i], exp_q[i]);
            end
        end
        n = err_got_q.size() - eb;
        tests++;
        if (n !== err_exp_q.size()) begin
            fails++;
            $display("FAIL random_err_count: got %0d need %0d", n, err_exp_q.size());
        end
        for (int i = 0; i < n && i < err_exp_q.size(); i++) begin
            tests++;
            if (err_got_q[eb+i] !== err_exp_q[i]) begin
                fails++;
                $display("FAIL random_err_vc%0d: got %0d need %0d", i, err_got_q[eb+i], err_exp_q[i]);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        flit_valid_i = 1'b0;
        flit_data_i  = '0;
        flit_vc_i    = '0;
        pkt_ready_i  = 1'b1;
        test_reset();
        test_basic_pkt();
        test_zero_size();
        test_interleave();
        test_backpressure();
        test_errors();
        test_size_check();
        test_reset_mid_pkt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
